// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg
// Shared definitions for the E-stage multiply/divide unit:
//   - 4-bit MDU opcode encodings (MD_NONE .. MD_MTLO; 9-15 behave as none)
//   - opcode class helpers is_md_start() and is_md_any()
//   - default busy latencies for multiply and divide
// -----------------------------------------------------------------------------
package md_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // Opcodes that launch a multi-cycle operation.
  function automatic logic is_md_start(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

  // Any opcode that touches the MDU (and therefore must wait while busy).
  function automatic logic is_md_any(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_MTLO);
  endfunction

  function automatic int md_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/md_arith.sv
// -----------------------------------------------------------------------------
// md_arith
// Combinational result generator for mult/multu/div/divu.
// Ports:
//   op_i  [3:0]  MDU opcode (only 1..4 produce a result)
//   a_i   [31:0] rs operand (multiplicand / dividend)
//   b_i   [31:0] rt operand (multiplier / divisor)
//   hi_o  [31:0] product high word, or remainder
//   lo_o  [31:0] product low word, or quotient
//   dz_o         divide opcode with a zero divisor (result must be discarded)
// -----------------------------------------------------------------------------
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        dz_o
);

  logic [63:0]        prod_s;
  logic [63:0]        a_sx_s;
  logic [63:0]        b_sx_s;
  logic signed [31:0] a_sg_s;
  logic signed [31:0] b_sg_s;

  // Sign-extending to 64 bits makes the low 64 bits of a plain product the
  // signed product, so one multiplier form serves both mult flavours.
  assign a_sx_s = {{32{a_i[31]}}, a_i};
  assign b_sx_s = {{32{b_i[31]}}, b_i};
  assign a_sg_s = a_i;
  assign b_sg_s = b_i;

  // Select and compute the HI/LO pair for the requested operation.
  always_comb begin
    prod_s = 64'd0;
    hi_o   = 32'd0;
    lo_o   = 32'd0;
    dz_o   = 1'b0;
    case (op_i)
      MD_MULT: begin
        prod_s = a_sx_s * b_sx_s;
        hi_o   = prod_s[63:32];
        lo_o   = prod_s[31:0];
      end
      MD_MULTU: begin
        prod_s = {32'd0, a_i} * {32'd0, b_i};
        hi_o   = prod_s[63:32];
        lo_o   = prod_s[31:0];
      end
      MD_DIV: begin
        if (b_i == 32'd0) begin
          dz_o = 1'b1;
        end else if ((a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF)) begin
          // The only signed overflow: quotient wraps back to the dividend.
          lo_o = 32'h8000_0000;
          hi_o = 32'd0;
        end else begin
          lo_o = a_sg_s / b_sg_s;
          hi_o = a_sg_s % b_sg_s;
        end
      end
      MD_DIVU: begin
        if (b_i == 32'd0) begin
          dz_o = 1'b1;
        end else begin
          lo_o = a_i / b_i;
          hi_o = a_i % b_i;
        end
      end
      default: begin
        hi_o = 32'd0;
        lo_o = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit_seq.sv
// -----------------------------------------------------------------------------
// md_unit_seq
// E-stage multi-cycle multiply/divide unit with architectural HI/LO.
// Ports:
//   clk        pipeline clock
//   reset      asynchronous active-high reset, clears all state
//   op_d [3:0] MDU opcode in D (stall decision only)
//   op_e [3:0] MDU opcode in E (present for one cycle per instruction)
//   rs_val/rt_val [31:0] forwarded E-stage operands
//   out  [31:0] mfhi/mflo read value (combinational, 0 for other opcodes)
//   stall_mdu  hold F/D and bubble E
//   busy       multiply/divide in flight
// The result is computed at launch and held in pending registers; it is
// committed to HI/LO on the edge that ends the programmed latency.
// -----------------------------------------------------------------------------
module md_unit_seq
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op_d,
  input  logic [3:0]  op_e,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] out,
  output logic        stall_mdu,
  output logic        busy
);

  localparam int CNT_W = $clog2(md_max(MULT_CYCLES, DIV_CYCLES) + 1);
  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_dz_q, pend_dz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic             start_s;
  logic [31:0]      res_hi_s;
  logic [31:0]      res_lo_s;
  logic             res_dz_s;

  md_arith u_arith (
    .op_i (op_e),
    .a_i  (rs_val),
    .b_i  (rt_val),
    .hi_o (res_hi_s),
    .lo_o (res_lo_s),
    .dz_o (res_dz_s)
  );

  // A launch opcode arriving while busy is illegal and simply ignored.
  assign start_s = is_md_start(op_e) && !busy_q;

  // Next-state logic: launch, count down/commit, or accept mthi/mtlo.
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    if (start_s) begin
      pend_hi_d = res_hi_s;
      pend_lo_d = res_lo_s;
      pend_dz_d = res_dz_s;
      cnt_d     = ((op_e == MD_MULT) || (op_e == MD_MULTU)) ? MULT_LD : DIV_LD;
      busy_d    = 1'b1;
    end else if (busy_q) begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        busy_d = 1'b0;
        // A zero divisor still burns the full latency but leaves HI/LO alone.
        if (!pend_dz_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end else begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      end else begin
        busy_d = 1'b1;
      end
    end else if (op_e == MD_MTHI) begin
      hi_d = rs_val;
    end else if (op_e == MD_MTLO) begin
      lo_d = rs_val;
    end else begin
      hi_d = hi_q;
      lo_d = lo_q;
    end
  end

  // State registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_dz_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  // mfhi/mflo read mux.
  always_comb begin
    out = 32'd0;
    case (op_e)
      MD_MFHI: out = hi_q;
      MD_MFLO: out = lo_q;
      default: out = 32'd0;
    endcase
  end

  // Including start means an MDU instruction right behind a launch waits too.
  assign stall_mdu = is_md_any(op_d) && (busy_q || start_s);
  assign busy      = busy_q;

endmodule

// File: tb/tb_md_unit_seq.sv
module tb_md_unit_seq;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op_d;
  logic [3:0]  op_e;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] out;
  logic        stall_mdu;
  logic        busy;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  md_unit_seq #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_d      (op_d),
    .op_e      (op_e),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .out       (out),
    .stall_mdu (stall_mdu),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest expected result and read it back through mfhi then mflo.
  task automatic read_hilo(input string tag);
    res_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      op_d = MD_NONE;
      op_e = MD_MFHI;
      #1;
      chk({tag, "_hi"}, out, e.hi);
      tick();
      op_e = MD_MFLO;
      #1;
      chk({tag, "_lo"}, out, e.lo);
      tick();
      op_e = MD_NONE;
    end
  endtask

  // Launch one operation, watch busy/stall for its whole life, then read.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int cyc, input logic [3:0] dop);
    int   n;
    logic exp_st;
    exp_st = (dop >= 4'd1) && (dop <= 4'd8);
    sb_q.push_back({eh, el});
    op_e = op; rs_val = a; rt_val = b; op_d = dop;
    #1;
    chk({tag, "_stall_at_start"}, 32'(stall_mdu), 32'(exp_st));
    tick();
    op_e = MD_NONE;
    #1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      chk({tag, "_stall_busy"}, 32'(stall_mdu), 32'(exp_st));
      tick();
    end
    chk({tag, "_busy_cycles"}, n, cyc);
    chk({tag, "_stall_after"}, 32'(stall_mdu), 32'd0);
    read_hilo(tag);
  endtask

  initial begin
    int          n;
    logic [3:0]  rop;
    logic [31:0] ra, rb, eh, el;
    logic [63:0] p;
    int          sa, sb, q, r;

    reset = 1'b1; op_d = MD_NONE; op_e = MD_NONE; rs_val = 32'd0; rt_val = 32'd0;
    #2;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_stall", 32'(stall_mdu), 32'd0);
    op_e = MD_MFHI; #1;
    chk("reset_hi", out, 32'd0);
    op_e = MD_MFLO; #1;
    chk("reset_lo", out, 32'd0);
    op_e = MD_NONE;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Directed cases.
    run_op("mult_m2x3", MD_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, MD_NONE);
    run_op("multu_ffx2", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, MD_MFHI);
    run_op("div_m7d2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, MD_NONE);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10, MD_MFLO);

    // Divide by zero keeps the values written by mthi/mtlo.
    op_e = MD_MTHI; rs_val = 32'h0000_1234; tick();
    op_e = MD_MTLO; rs_val = 32'h0000_5678; tick();
    run_op("divu_z", MD_DIVU, 32'd99, 32'd0, 32'h0000_1234, 32'h0000_5678, 10, MD_NONE);

    // Reset in the middle of a multiply.
    op_e = MD_MULT; rs_val = 32'd3; rt_val = 32'd4; tick();
    op_e = MD_NONE; tick();
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    op_d = MD_MULT; op_e = MD_MFHI; #1;
    chk("rst_mid_stall", 32'(stall_mdu), 32'd0);
    chk("rst_mid_hi", out, 32'd0);
    op_e = MD_MFLO; #1;
    chk("rst_mid_lo", out, 32'd0);
    op_e = MD_NONE; op_d = MD_NONE;
    tick();
    reset = 1'b0;
    repeat (12) tick();
    chk("rst_after_busy", 32'(busy), 32'd0);
    op_e = MD_MFHI; #1;
    chk("rst_after_hi", out, 32'd0);
    op_e = MD_MFLO; #1;
    chk("rst_after_lo", out, 32'd0);
    op_e = MD_NONE;
    tick();

    // Non-MDU instruction in D never stalls; mthi in D stalls until done.
    // An illegal launch while busy must be ignored.
    op_e = MD_MULT; rs_val = 32'd5; rt_val = 32'd6; op_d = MD_NONE; #1;
    chk("addu_stall_start", 32'(stall_mdu), 32'd0);
    tick();
    op_e = MD_NONE; #1;
    chk("addu_busy", 32'(busy), 32'd1);
    chk("addu_stall_busy", 32'(stall_mdu), 32'd0);
    op_d = MD_MTHI; #1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      chk("mthi_stall_busy", 32'(stall_mdu), 32'd1);
      if (n == 2) begin
        op_e = MD_MULTU; rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF;
      end else begin
        op_e = MD_NONE;
      end
      tick();
    end
    op_e = MD_NONE; #1;
    chk("mthi_busy_cycles", n, 32'd5);
    chk("mthi_stall_after", 32'(stall_mdu), 32'd0);
    op_d = MD_NONE; op_e = MD_MTHI; rs_val = 32'h0000_CAFE; tick();
    op_e = MD_NONE;
    sb_q.push_back({32'h0000_CAFE, 32'd30});
    read_hilo("mthi_after_mult");

    // Randomised operations against a bench-side arithmetic model.
    for (int i = 0; i < 6; i++) begin
      rop = 4'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = $urandom;
      if (rb == 32'd0) rb = 32'd7;
      if (i == 5) rb = 32'($urandom_range(1, 9));
      if (rop == MD_DIV && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      case (rop)
        MD_MULT: begin
          p  = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
          eh = p[63:32]; el = p[31:0];
        end
        MD_MULTU: begin
          p  = {32'd0, ra} * {32'd0, rb};
          eh = p[63:32]; el = p[31:0];
        end
        MD_DIV: begin
          sa = ra; sb = rb;
          q  = sa / sb; r = sa % sb;
          eh = r; el = q;
        end
        default: begin
          eh = ra % rb; el = ra / rb;
        end
      endcase
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, eh, el,
             (rop <= MD_MULTU) ? 5 : 10, 4'($urandom_range(0, 8)));
    end

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
